// File: rtl/ascon_perm_core.sv
// ascon_perm_core: iterated Ascon permutation p^a/p^b, UNROLL rounds per clock,
// behind a start/done handshake with a registered 320-bit state.
module ascon_perm_core #(
    parameter int UNROLL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  rounds,
    input  logic [63:0] x0,
    input  logic [63:0] x1,
    input  logic [63:0] x2,
    input  logic [63:0] x3,
    input  logic [63:0] x4,
    output logic        ready,
    output logic        done,
    output logic        valid,
    output logic [63:0] y0,
    output logic [63:0] y1,
    output logic [63:0] y2,
    output logic [63:0] y3,
    output logic [63:0] y4
);
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 4 || UNROLL == 6 || UNROLL == 12)) begin : g_bad_unroll
        $error("ascon_perm_core: UNROLL must be 1, 2, 3, 4, 6 or 12");
    end

    typedef logic [4:0][63:0] st_t;
    typedef enum logic {IDLE, RUN} state_t;

    state_t     state, state_nxt;
    st_t        st, cur;
    logic [3:0] ri, rem, rem_nxt, rc;
    logic       fin, accept;

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic st_t round_f(input st_t s, input logic [3:0] i);
        logic [63:0] a0, a1, a2, a3, a4, b0, b1, b2, b3, b4;
        st_t r;
        a0 = s[0] ^ s[4];
        a1 = s[1];
        a2 = s[2] ^ {56'b0, 4'hF - i, i} ^ s[1];
        a3 = s[3];
        a4 = s[4] ^ s[3];
        b0 = a0 ^ (~a1 & a2);
        b1 = a1 ^ (~a2 & a3);
        b2 = a2 ^ (~a3 & a4);
        b3 = a3 ^ (~a4 & a0);
        b4 = a4 ^ (~a0 & a1);
        b1 = b1 ^ b0;
        b0 = b0 ^ b4;
        b3 = b3 ^ b2;
        b2 = ~b2;
        r[0] = b0 ^ ror(b0, 19) ^ ror(b0, 28);
        r[1] = b1 ^ ror(b1, 61) ^ ror(b1, 39);
        r[2] = b2 ^ ror(b2, 1) ^ ror(b2, 6);
        r[3] = b3 ^ ror(b3, 10) ^ ror(b3, 17);
        r[4] = b4 ^ ror(b4, 7) ^ ror(b4, 41);
        return r;
    endfunction

    // stages beyond the remaining count pass the state through untouched
    always_comb begin
        cur = st;
        for (int j = 0; j < UNROLL; j++)
            cur = (4'(j) < rem) ? round_f(cur, ri + 4'(j)) : cur;
    end

    assign rc      = rounds > 4'd12 ? 4'd12 : rounds;
    assign rem_nxt = rem > 4'(UNROLL) ? rem - 4'(UNROLL) : 4'd0;
    assign fin     = state == RUN && rem_nxt == 4'd0;
    assign accept  = ready && start;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nxt;

    always_comb
        state_nxt = state == IDLE ? (start ? RUN : IDLE) : (rem_nxt == 4'd0 ? IDLE : RUN);

    always_comb
        ready = state == IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st    <= '0;
            ri    <= '0;
            rem   <= '0;
            done  <= 1'b0;
            valid <= 1'b0;
        end else begin
            done  <= fin;
            valid <= fin ? 1'b1 : (accept ? 1'b0 : valid);
            if (accept) begin
                st  <= {x4, x3, x2, x1, x0};
                ri  <= 4'd12 - rc;
                rem <= rc;
            end else if (state == RUN) begin
                st  <= cur;
                ri  <= ri + 4'(UNROLL);
                rem <= rem_nxt;
            end
        end
    end

    assign y0 = st[0];
    assign y1 = st[1];
    assign y2 = st[2];
    assign y3 = st[3];
    assign y4 = st[4];
endmodule

// File: tb/tb_ascon_perm_core.sv
// tb_ascon_perm_core: three cores (UNROLL 1, 4, 12) checked every cycle against
// a transaction-level Ascon model, plus directed latency and handshake vectors.
module tb_ascon_perm_core;
    typedef logic [4:0][63:0] st_t;
    localparam int UN [3] = '{1, 4, 12};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start [3];
    logic [3:0]  rounds [3];
    st_t         x [3];
    logic        ready [3], done [3], valid [3];
    logic [63:0] yw [3][5];

    st_t  m_y [3], m_res [3];
    logic m_ready [3], m_done [3], m_valid [3];
    int   m_cnt [3];
    int   ncmp = 0, nerr = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ascon_perm_core #(.UNROLL(UN[g])) dut (
            .clk(clk), .rst(rst), .start(start[g]), .rounds(rounds[g]),
            .x0(x[g][0]), .x1(x[g][1]), .x2(x[g][2]), .x3(x[g][3]), .x4(x[g][4]),
            .ready(ready[g]), .done(done[g]), .valid(valid[g]),
            .y0(yw[g][0]), .y1(yw[g][1]), .y2(yw[g][2]), .y3(yw[g][3]), .y4(yw[g][4])
        );
    end

    function automatic logic [63:0] rotr(logic [63:0] v, int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic st_t rnd(st_t s, int i);
        st_t t;
        int ra [5] = '{19, 61, 1, 10, 7};
        int rb [5] = '{28, 39, 6, 17, 41};
        s[2] ^= 64'(240 - 15 * i);
        s[0] ^= s[4]; s[4] ^= s[3]; s[2] ^= s[1];
        for (int k = 0; k < 5; k++) t[k] = ~s[k] & s[(k + 1) % 5];
        for (int k = 0; k < 5; k++) s[k] ^= t[(k + 1) % 5];
        s[1] ^= s[0]; s[0] ^= s[4]; s[3] ^= s[2]; s[2] = ~s[2];
        for (int k = 0; k < 5; k++) s[k] = s[k] ^ rotr(s[k], ra[k]) ^ rotr(s[k], rb[k]);
        return s;
    endfunction

    function automatic st_t perm(st_t s, int r);
        int rr = r > 12 ? 12 : r;
        for (int i = 12 - rr; i < 12; i++) s = rnd(s, i);
        return s;
    endfunction

    function automatic int lat(int u, int r);
        int rr = r > 12 ? 12 : r;
        int k = (rr + u - 1) / u;
        return k < 1 ? 1 : k;
    endfunction

    function automatic st_t rand_st();
        st_t s;
        for (int k = 0; k < 5; k++) s[k] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic chk(string nm, int d, logic [63:0] act, logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s dut%0d: got %h expected %h", nm, d, act, exp);
        end
    endtask

    // transaction model: accept when idle, result appears after lat() edges
    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                m_y[d] <= '0; m_ready[d] <= 1'b1; m_done[d] <= 1'b0;
                m_valid[d] <= 1'b0; m_cnt[d] <= 0;
            end else begin
                m_done[d] <= 1'b0;
                if (m_ready[d]) begin
                    if (start[d]) begin
                        m_y[d] <= x[d];
                        m_res[d] <= perm(x[d], int'(rounds[d]));
                        m_cnt[d] <= lat(UN[d], int'(rounds[d]));
                        m_ready[d] <= 1'b0;
                        m_valid[d] <= 1'b0;
                    end
                end else if (m_cnt[d] == 1) begin
                    m_y[d] <= m_res[d]; m_ready[d] <= 1'b1;
                    m_done[d] <= 1'b1; m_valid[d] <= 1'b1;
                end else m_cnt[d] <= m_cnt[d] - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 3; d++) begin
                chk("ready", d, 64'(ready[d]), 64'(m_ready[d]));
                chk("done", d, 64'(done[d]), 64'(m_done[d]));
                chk("valid", d, 64'(valid[d]), 64'(m_valid[d]));
                if (m_valid[d])
                    for (int k = 0; k < 5; k++) chk($sformatf("y%0d", k), d, yw[d][k], m_y[d][k]);
            end
        end
    end

    task automatic wait_idle(int d);
        int n = 0;
        while (!m_ready[d] && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) begin nerr++; ncmp++; $display("FAIL idle_timeout dut%0d: got busy expected idle", d); end
    endtask

    task automatic wait_done(int d, output int n);
        n = 0;
        while (!done[d] && n < 40) begin @(posedge clk); #1; n++; end
    endtask

    task automatic req(int d, int r, st_t v);
        int n;
        st_t e = perm(v, r);
        wait_idle(d);
        start[d] = 1'b1; rounds[d] = 4'(r); x[d] = v;
        @(posedge clk); #1;
        start[d] = 1'b0; rounds[d] = 4'($urandom); x[d] = rand_st();
        wait_done(d, n);
        chk($sformatf("latency_r%0d", r), d, 64'(n), 64'(lat(UN[d], r)));
        for (int k = 0; k < 5; k++) chk($sformatf("res_r%0d_y%0d", r, k), d, yw[d][k], e[k]);
    endtask

    task automatic reset_checks(string nm);
        for (int d = 0; d < 3; d++) begin
            chk({nm, "_ready"}, d, 64'(ready[d]), 64'd1);
            chk({nm, "_done"}, d, 64'(done[d]), 64'd0);
            chk({nm, "_valid"}, d, 64'(valid[d]), 64'd0);
            for (int k = 0; k < 5; k++) chk($sformatf("%s_y%0d", nm, k), d, yw[d][k], 64'd0);
        end
    endtask

    initial begin
        st_t iv, z, p1, v1, v3;
        int n;
        iv = {64'h9BF367D58FD211FF, 64'h369C801F3AE8D0EA, 64'hC74F26B30A8C44B2,
              64'h265F1C12888E151A, 64'h80400C0600000000};
        z = '0;
        for (int d = 0; d < 3; d++) begin start[d] = 1'b0; rounds[d] = '0; x[d] = '0; end
        #2 rst = 1'b1;
        #1 reset_checks("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // one round, index 0, on the zero state (worked by hand)
        p1 = rnd(z, 0);
        chk("model_y0", 0, p1[0], 64'h001E0F00000000F0);
        chk("model_y1", 0, p1[1], 64'h00000001E0000770);
        chk("model_y2", 0, p1[2], 64'h3FFFFFFFFFFFFF74);
        chk("model_y3", 0, p1[3], 64'h3C780000000000F0);
        chk("model_y4", 0, p1[4], 64'h0);

        for (int d = 0; d < 3; d++) req(d, 12, iv);
        for (int d = 0; d < 3; d++) req(d, 6, z);
        for (int d = 0; d < 3; d++) req(d, 0, iv);
        for (int d = 0; d < 3; d++) req(d, 15, iv);
        req(0, 3, rand_st());
        req(1, 5, rand_st());
        req(2, 1, rand_st());
        req(1, 9, rand_st());

        // start during RUN is ignored; start in the done cycle is accepted
        wait_idle(0);
        v1 = rand_st();
        start[0] = 1'b1; rounds[0] = 4'd12; x[0] = v1;
        @(posedge clk); #1; start[0] = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        start[0] = 1'b1; rounds[0] = 4'd2; x[0] = rand_st();
        @(posedge clk); #1; start[0] = 1'b0;
        wait_done(0, n);
        chk("hs_latency", 0, 64'(n), 64'd8);
        p1 = perm(v1, 12);
        for (int k = 0; k < 5; k++) chk($sformatf("hs_first_y%0d", k), 0, yw[0][k], p1[k]);
        v3 = rand_st();
        start[0] = 1'b1; rounds[0] = 4'd6; x[0] = v3;
        @(posedge clk); #1; start[0] = 1'b0;
        chk("b2b_valid_low", 0, 64'(valid[0]), 64'd0);
        chk("b2b_ready_low", 0, 64'(ready[0]), 64'd0);
        wait_done(0, n);
        chk("b2b_latency", 0, 64'(n), 64'd6);
        p1 = perm(v3, 6);
        for (int k = 0; k < 5; k++) chk($sformatf("b2b_y%0d", k), 0, yw[0][k], p1[k]);

        // reset mid-run aborts with no done
        wait_idle(0);
        start[0] = 1'b1; rounds[0] = 4'd12; x[0] = iv;
        @(posedge clk); #1; start[0] = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        #1 reset_checks("midrst");
        #1 rst = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        req(0, 12, iv);
        req(1, 12, iv);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/ascon_perm_core.md
# ascon_perm_core

Sequential, iterated Ascon permutation core (p^a / p^b) with a configurable round count per request and a parametrised number of rounds unrolled per clock. It replaces the purely combinational permutation path in the demo datapath. Initialization, data-processing and finalization callers share one registered 320-bit state behind a start/done handshake.

## Interface
- `UNROLL`, default 1: rounds computed per clock. Legal values are 1, 2, 3, 4, 6, 12; any other value is a synthesis error.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request strobe; accepted only when `ready`=1.
- `rounds`  in  4  number of rounds for this request, sampled with `start`.
- `x0`..`x4`  in  64 each  input state words, sampled with `start`.
- `ready`  out  1  core idle and able to accept `start`.
- `done`  out  1  one-cycle pulse: result is available.
- `valid`  out  1  `y*` holds a completed result; stays high until the next accepted `start`.
- `y0`..`y4`  out  64 each  state register; holds the final state after `done`.

## Operation
- States:
  - IDLE: `ready`=1.
  - RUN: `ready`=0.
  - Transitions: IDLE→RUN on an accepted `start`; RUN→IDLE when the remaining round count reaches 0.
- On an accepted start:
  - load `x0..x4` into the state register, clear `valid`;
  - set the round index to ri = 12 − r, where r = `rounds`;
  - r = 0 is allowed: the state passes through unchanged;
  - r > 12 is clamped to 12.
- Each RUN cycle applies n = min(UNROLL, remaining) rounds, using indices ri, ri+1, …, ri+n−1. Unused unrolled stages are bypassed.
- Round i applies these steps in order:
  - Constant addition: x2 ^= {56'b0, (4'hF − i[3:0]), i[3:0]}, so i=0 gives 0xF0 and i=11 gives 0x4B.
  - Substitution layer: the Ascon 5-bit S-box, bitsliced across x0..x4. Sequence:
    - x0^=x4; x4^=x3; x2^=x1;
    - t_k = ~x_k & x_{k+1 mod 5};
    - x_k ^= t_{k+1 mod 5};
    - x1^=x0; x0^=x4; x3^=x2; x2=~x2.
  - Linear layer (rotate-right amounts):
    - x0 ^= (x0>>>19) ^ (x0>>>28)
    - x1 ^= (x1>>>61) ^ (x1>>>39)
    - x2 ^= (x2>>>1) ^ (x2>>>6)
    - x3 ^= (x3>>>10) ^ (x3>>>17)
    - x4 ^= (x4>>>7) ^ (x4>>>41)
- Word order: x0 is the Ascon S0 word. Bit 63 is the MSB of the big-endian byte string.
- Round-count arithmetic is 4-bit unsigned. The remaining count never underflows.

## Timing
- Reset values:
  - `y0..y4` = 0, `valid` = 0, `done` = 0, `ready` = 1.
  - FSM in IDLE, round counters 0.
- Start accepted at edge N: the state is loaded at N, `ready` drops after N.
- Rounds execute on edges N+1 … N+k, where k = max(1, ceil(r/UNROLL)). For r = 0, edge N+1 performs no round.
- `done`=1 and `valid`=1 after edge N+k. `done` falls after edge N+k+1. `ready` returns to 1 after edge N+k.
- Back-to-back: `start` is accepted in the cycle where `done`=1 (ready=1). The new request loads at that edge and `valid` clears.
- `start` while `ready`=0 is ignored; there is no queuing. `rounds` and `x*` may change freely while RUN.
- `y*` shows intermediate state during RUN. Consumers use it only when `valid`=1.
- `rst` asserted mid-RUN immediately returns all outputs to their reset values and aborts the request. No `done` is issued.

## Test plan
- Reset mid-operation:
  - Stimulus: UNROLL=1, start with rounds=12, assert `rst` at cycle 5.
  - Required response: y*=0, ready=1, valid=0 immediately; no `done` pulse; a subsequent request completes normally.
- Ascon-128 init, UNROLL=1:
  - Stimulus: `x0`=80400C0600000000, `x1`=265F1C12888E151A, `x2`=C74F26B30A8C44B2, `x3`=369C801F3AE8D0EA, `x4`=9BF367D58FD211FF, rounds=12.
  - Required response: `done` exactly 12 cycles after the start edge; y* equals the bench's bit-exact p^12 model.
- Same init vector with UNROLL=4, then UNROLL=12:
  - Required response: identical y*; `done` after 3 cycles and 1 cycle respectively.
- p^6 with non-divisible unroll:
  - Stimulus: UNROLL=4, rounds=6, state all-zero.
  - Required response: `done` after 2 cycles; result equals the model applying round indices 6..11 (constants 0x96, 0x87, 0x78, 0x69, 0x5A, 0x4B).
- Edge round counts:
  - rounds=0: `done` after 1 cycle; y* equals the input.
  - rounds=15: identical to rounds=12.
- Handshake:
  - Stimulus: a `start` pulse during RUN.
  - Required response: ignored; the first result is unaffected.
  - Stimulus: `start` in the `done` cycle.
  - Required response: accepted; `valid` drops next cycle; the second result is correct.
